// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one round per clock over an expanded key
// schedule. AES-128/192/256 are selected by Nk = 4/6/8 (Nr = Nk + 6).
module aes_cipher_iter #(
  parameter int NR_MAX = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [127:0]                  plaintext,
  input  logic [32*4*(NR_MAX+1)-1:0]    w,
  input  logic [3:0]                    Nk,
  input  logic                          key_ready,
  output logic [127:0]                  ciphertext,
  output logic                          busy,
  output logic                          valid,
  output logic                          err
);

  localparam int W_BITS = 32 * 4 * (NR_MAX + 1);

  // FIPS-197 S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   nr_q, nr_d;
  logic [127:0] st_q, st_d;
  logic [127:0] ct_q, ct_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  logic         nk_ok;
  logic [127:0] sr_state;
  logic [127:0] mc_state;
  logic [127:0] rk_cur;
  logic [127:0] rk_zero;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TAB[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of the state lives at [127-8i -: 8]; row = i%4, column = i/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Round key r: schedule word 4r becomes the most significant column.
  function automatic logic [127:0] round_key(input logic [W_BITS-1:0] wv,
                                             input logic [3:0] r);
    logic [127:0] k;
    k = '0;
    for (int c = 0; c < 4; c++) begin
      k[127 - 32*c -: 32] = wv[128*int'(r) + 32*c +: 32];
    end
    return k;
  endfunction

  // Shared round datapath: SubBytes, ShiftRows, MixColumns and key selection.
  always_comb begin
    sr_state = shift_rows({sub_word(st_q[127:96]), sub_word(st_q[95:64]),
                           sub_word(st_q[63:32]),  sub_word(st_q[31:0])});
    mc_state = {mix_col(sr_state[127:96]), mix_col(sr_state[95:64]),
                mix_col(sr_state[63:32]),  mix_col(sr_state[31:0])};
    rk_cur   = round_key(w, rnd_q);
    rk_zero  = round_key(w, 4'd0);
    nk_ok    = (Nk == 4'd4) || (Nk == 4'd6) || (Nk == 4'd8);
  end

  // Next-state and output decode; valid and err are single-cycle pulses.
  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    nr_d    = nr_q;
    st_d    = st_q;
    ct_d    = ct_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (start && key_ready) begin
          if (nk_ok) begin
            st_d  = plaintext ^ rk_zero;
            rnd_d = 4'd1;
            nr_d  = Nk + 4'd6;
            fsm_d = S_ROUND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ROUND: begin
        st_d  = mc_state ^ rk_cur;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == nr_q - 4'd1) begin
          fsm_d = S_FINAL;
        end
      end
      S_FINAL: begin
        ct_d    = sr_state ^ rk_cur;
        valid_d = 1'b1;
        rnd_d   = 4'd0;
        fsm_d   = S_IDLE;
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= S_IDLE;
      rnd_q   <= 4'd0;
      nr_q    <= 4'd0;
      st_q    <= '0;
      ct_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      nr_q    <= nr_d;
      st_q    <= st_d;
      ct_q    <= ct_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ciphertext = ct_q;
  assign busy       = (fsm_q != S_IDLE);
  assign valid      = valid_q;
  assign err        = err_q;

endmodule
